mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/rr_select3.sv | 33 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-port SDRAM burst arbiter.
package mem_arbiter_pkg;

  // Arbiter sequencing: one grant cycle, the data beats, one release cycle.
  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBurst,
    StRelease
  } state_e;

  // Owner encodings, also used as the round-robin last-granted pointer.
  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntP1   = 2'd1;
  localparam logic [1:0] GntP2   = 2'd2;
  localparam logic [1:0] GntP3   = 2'd3;

  // Every transaction is a fixed-length burst of 16-bit words.
  localparam int unsigned BurstLen = 4;
  localparam logic [1:0]  BeatLast = 2'(BurstLen - 1);

endpackage

// File: rtl/rr_select3.sv
// Three-way round-robin selector: picks the first requester after the last owner.
module rr_select3
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner
);

  // Scan order rotates so the port granted last has lowest priority.
  always_comb begin
    winner = GntNone;
    case (last)
      GntP1: begin
        if (req[1])      winner = GntP2;
        else if (req[2]) winner = GntP3;
        else if (req[0]) winner = GntP1;
      end
      GntP2: begin
        if (req[2])      winner = GntP3;
        else if (req[0]) winner = GntP1;
        else if (req[1]) winner = GntP2;
      end
      default: begin
        // GntP3, and the unused GntNone code, start the scan at p1.
        if (req[0])      winner = GntP1;
        else if (req[1]) winner = GntP2;
        else if (req[2]) winner = GntP3;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates p1 (program cache), p2 (data cache) and p3 onto one SDRAM burst port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned        ADDR_W  = 24,
  parameter logic [ADDR_W-1:0]  P3_BASE = 24'hFE0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_req,
  input  logic [31:0]       p1_address,
  output logic              p1_ready,
  output logic [1:0]        p1_offset,
  input  logic              p2_req,
  input  logic              p2_wren,
  input  logic [31:0]       p2_address,
  input  logic [15:0]       p2_to_mem,
  output logic              p2_ready,
  output logic [1:0]        p2_offset,
  input  logic              p3_req,
  input  logic              p3_wren,
  input  logic [16:0]       p3_address,
  input  logic [15:0]       p3_to_mem,
  output logic              p3_ready,
  output logic [1:0]        p3_offset,
  output logic              ctrl_req,
  output logic              ctrl_wren,
  output logic [ADDR_W-1:0] ctrl_address,
  output logic [15:0]       ctrl_to_mem,
  input  logic              ctrl_ready,
  input  logic [1:0]        ctrl_offset,
  output logic [1:0]        grant
);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] winner;
  logic       active;

  logic [ADDR_W-1:0] p1_word, p2_word, p3_word;

  // Bursts are word-aligned to four, so the two low address bits are always cleared.
  assign p1_word = {p1_address[ADDR_W-1:2], 2'b00};
  assign p2_word = {p2_address[ADDR_W-1:2], 2'b00};
  assign p3_word = {P3_BASE[ADDR_W-1:2] | {{(ADDR_W-17){1'b0}}, p3_address[16:2]}, 2'b00};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{p1_address[31:ADDR_W], p1_address[1:0],
                              p2_address[31:ADDR_W], p2_address[1:0], p3_address[1:0]};

  assign active = (state_q == StGrant) || (state_q == StBurst);
  assign grant  = grant_q;

  rr_select3 u_rr_select3 (
    .req    ({p3_req, p2_req, p1_req}),
    .last   (last_q),
    .winner (winner)
  );

  // State, owner, round-robin pointer and beat counter; reset drops the burst at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= GntNone;
      last_q  <= GntP3;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state: contest only in idle, count beats only while the burst port is owned.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        grant_d = GntNone;
        beat_d  = 2'd0;
        if (winner != GntNone) begin
          grant_d = winner;
          last_d  = winner;
          state_d = StGrant;
        end
      end
      StGrant, StBurst: begin
        if (state_q == StGrant) state_d = StBurst;
        if (ctrl_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == BeatLast) state_d = StRelease;
        end
      end
      StRelease: begin
        grant_d = GntNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output steering: request/address only while active, ready/offset/data follow the owner.
  always_comb begin
    ctrl_req     = active;
    ctrl_wren    = 1'b0;
    ctrl_address = '0;
    ctrl_to_mem  = 16'h0000;
    p1_ready     = 1'b0;
    p1_offset    = 2'b00;
    p2_ready     = 1'b0;
    p2_offset    = 2'b00;
    p3_ready     = 1'b0;
    p3_offset    = 2'b00;
    unique case (grant_q)
      GntP1: begin
        if (active) ctrl_address = p1_word;
        p1_ready  = active & ctrl_ready;
        p1_offset = ctrl_offset;
      end
      GntP2: begin
        if (active) begin
          ctrl_wren    = p2_wren;
          ctrl_address = p2_word;
        end
        ctrl_to_mem = p2_to_mem;
        p2_ready    = active & ctrl_ready;
        p2_offset   = ctrl_offset;
      end
      GntP3: begin
        if (active) begin
          ctrl_wren    = p3_wren;
          ctrl_address = p3_word;
        end
        ctrl_to_mem = p3_to_mem;
        p3_ready    = active & ctrl_ready;
        p3_offset   = ctrl_offset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with an SDRAM-controller model and a burst scoreboard.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        p1_req;
  logic [31:0] p1_address;
  logic        p1_ready;
  logic [1:0]  p1_offset;
  logic        p2_req, p2_wren;
  logic [31:0] p2_address;
  logic [15:0] p2_to_mem;
  logic        p2_ready;
  logic [1:0]  p2_offset;
  logic        p3_req, p3_wren;
  logic [16:0] p3_address;
  logic [15:0] p3_to_mem;
  logic        p3_ready;
  logic [1:0]  p3_offset;
  logic        ctrl_req, ctrl_wren;
  logic [23:0] ctrl_address;
  logic [15:0] ctrl_to_mem;
  logic        ctrl_ready;
  logic [1:0]  ctrl_offset;
  logic [1:0]  grant;

  mem_arbiter #(
    .ADDR_W  (24),
    .P3_BASE (24'hFE0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p1_req       (p1_req),
    .p1_address   (p1_address),
    .p1_ready     (p1_ready),
    .p1_offset    (p1_offset),
    .p2_req       (p2_req),
    .p2_wren      (p2_wren),
    .p2_address   (p2_address),
    .p2_to_mem    (p2_to_mem),
    .p2_ready     (p2_ready),
    .p2_offset    (p2_offset),
    .p3_req       (p3_req),
    .p3_wren      (p3_wren),
    .p3_address   (p3_address),
    .p3_to_mem    (p3_to_mem),
    .p3_ready     (p3_ready),
    .p3_offset    (p3_offset),
    .ctrl_req     (ctrl_req),
    .ctrl_wren    (ctrl_wren),
    .ctrl_address (ctrl_address),
    .ctrl_to_mem  (ctrl_to_mem),
    .ctrl_ready   (ctrl_ready),
    .ctrl_offset  (ctrl_offset),
    .grant        (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester and controller knobs set by the main sequence.
  bit [2:0]    en = 3'b000;
  int          rate = 0;
  bit          spur_en = 1'b1;
  bit          drop_en = 1'b0;
  int          phase = 0;
  bit          pend[3];
  bit          dropped[3];
  bit          drop_mid[3];
  int          cnt[3];
  logic [31:0] addr_r[3];
  bit          wren_r[3];
  logic [15:0] base_r[3];
  int          cbeat = 0;

  // Writers hand over base+offset for whichever word they are currently shown.
  assign p2_to_mem = base_r[1] + 16'(p2_offset);
  assign p3_to_mem = base_r[2] + 16'(p3_offset);

  // Requesters and SDRAM controller: count readies mid-cycle, drive just after the edge.
  initial begin
    for (int p = 0; p < 3; p++) begin
      pend[p] = 0; dropped[p] = 0; drop_mid[p] = 0; cnt[p] = 0;
      addr_r[p] = '0; wren_r[p] = 0; base_r[p] = '0;
    end
    forever begin
      @(negedge clk);
      if (p1_ready && pend[0]) cnt[0]++;
      if (p2_ready && pend[1]) cnt[1]++;
      if (p3_ready && pend[2]) cnt[2]++;
      @(posedge clk);
      #1;
      if (ctrl_req) begin
        if (cbeat < 4 && $urandom_range(0, 3) != 0) begin
          ctrl_ready  = 1'b1;
          ctrl_offset = 2'(cbeat);
          cbeat++;
        end else begin
          ctrl_ready = 1'b0;
        end
      end else begin
        cbeat       = 0;
        ctrl_ready  = spur_en && ($urandom_range(0, 3) == 0);
        ctrl_offset = 2'($urandom_range(0, 3));
      end
      for (int p = 0; p < 3; p++) begin
        if (!reset) begin
          pend[p] = 0; dropped[p] = 0; cnt[p] = 0;
        end else if (pend[p] && cnt[p] >= 4) begin
          pend[p] = 0; dropped[p] = 0; cnt[p] = 0;
        end else if (pend[p]) begin
          if (drop_mid[p] && cnt[p] >= 2) dropped[p] = 1;
        end else if (en[p] && $urandom_range(0, 99) < rate) begin
          pend[p]     = 1;
          dropped[p]  = 0;
          cnt[p]      = 0;
          drop_mid[p] = drop_en && (p == 1) && ($urandom_range(0, 2) == 0);
          addr_r[p]   = $urandom;
          wren_r[p]   = (p != 0) && ($urandom_range(0, 1) == 1);
          base_r[p]   = 16'($urandom);
          if (phase == 1) begin
            if (p == 0) addr_r[p] = 32'h0000_1236;
            if (p == 2) begin
              addr_r[p] = 32'h0000_0010;
              wren_r[p] = 1;
              base_r[p] = 16'hA000;
            end
          end
        end
      end
      p1_req     = pend[0] && !dropped[0];
      p1_address = addr_r[0];
      p2_req     = pend[1] && !dropped[1];
      p2_address = addr_r[1];
      p2_wren    = wren_r[1];
      p3_req     = pend[2] && !dropped[2];
      p3_address = addr_r[2][16:0];
      p3_wren    = wren_r[2];
    end
  end

  typedef struct {
    int          port;
    logic        wren;
    logic [23:0] addr;
    logic [15:0] base;
  } txn_t;

  txn_t exp_q[$];
  int   mdl_mode = 0;   // 0 bus free, 1 burst owned, 2 release
  int   mdl_last = 3;
  int   mdl_port = 0;
  int   mdl_beats = 0;

  // Reference model: decides each contest, predicts owner and request line per cycle.
  initial begin
    bit [2:0] reqv;
    int       win;
    txn_t     t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ctrl_req", 32'(ctrl_req), 0);
        chk("rst_ctrl_wren", 32'(ctrl_wren), 0);
        chk("rst_ctrl_address", 32'(ctrl_address), 0);
        chk("rst_readies", 32'({p3_ready, p2_ready, p1_ready}), 0);
        mdl_mode = 0; mdl_last = 3; mdl_port = 0; mdl_beats = 0;
        exp_q.delete();
      end else begin
        chk("grant", 32'(grant), (mdl_mode == 0) ? 32'd0 : 32'(mdl_port));
        chk("ctrl_req", 32'(ctrl_req), (mdl_mode == 1) ? 32'd1 : 32'd0);
        if (mdl_mode == 0) begin
          reqv = {p3_req, p2_req, p1_req};
          win  = 0;
          for (int k = 1; k <= 3; k++) begin
            int cand;
            cand = (mdl_last + k - 1) % 3 + 1;
            if (win == 0 && reqv[cand-1]) win = cand;
          end
          if (win != 0) begin
            t.port = win;
            t.base = base_r[win-1];
            if (win == 1) begin
              t.wren = 1'b0;
              t.addr = p1_address[23:0] & 24'hFFFFFC;
            end else if (win == 2) begin
              t.wren = p2_wren;
              t.addr = p2_address[23:0] & 24'hFFFFFC;
            end else begin
              t.wren = p3_wren;
              t.addr = (24'hFE0000 | {7'd0, p3_address}) & 24'hFFFFFC;
            end
            exp_q.push_back(t);
            mdl_port = win; mdl_last = win; mdl_beats = 0; mdl_mode = 1;
          end
        end else if (mdl_mode == 1) begin
          if (ctrl_ready) begin
            mdl_beats++;
            if (mdl_beats == 4) mdl_mode = 2;
          end
        end else begin
          mdl_mode = 0;
        end
      end
    end
  end

  bit   log_seq = 0;
  int   gseq[$];

  // Monitor: pops the predicted burst when ctrl_req rises, checks every beat it carries.
  initial begin
    txn_t       cur;
    bit         cur_valid = 0;
    int         mon_seen = 0;
    logic       req_prev = 0;
    logic [5:0] exp_off;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_valid = 0; mon_seen = 0; req_prev = 0;
      end else begin
        if (ctrl_req && !req_prev) begin
          chk("burst_predicted", 32'(exp_q.size()), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cur_valid = 1;
            mon_seen = 0;
            if (log_seq) gseq.push_back(int'(grant));
            chk("burst_grant", 32'(grant), 32'(cur.port));
            chk("burst_address", 32'(ctrl_address), 32'(cur.addr));
            chk("burst_wren", 32'(ctrl_wren), 32'(cur.wren));
          end
        end
        if (ctrl_ready) begin
          if (ctrl_req && cur_valid) begin
            exp_off = '0;
            exp_off[2*(cur.port-1) +: 2] = ctrl_offset;
            chk("beat_readies", 32'({p3_ready, p2_ready, p1_ready}), 32'(3'b001 << (cur.port - 1)));
            chk("beat_offsets", 32'({p3_offset, p2_offset, p1_offset}), 32'(exp_off));
            chk("beat_to_mem", 32'(ctrl_to_mem),
                (cur.port == 1) ? 32'd0 : 32'(cur.base + 16'(mon_seen)));
            mon_seen++;
          end else if (!ctrl_req) begin
            chk("ignored_ready", 32'({p3_ready, p2_ready, p1_ready}), 0);
          end
        end
        if (!ctrl_req && req_prev && cur_valid) begin
          chk("beats_per_burst", 32'(mon_seen), 4);
          cur_valid = 0;
        end
        req_prev = ctrl_req;
      end
    end
  end

  task automatic wait_quiet(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (mdl_mode == 0 && !pend[0] && !pend[1] && !pend[2] && !ctrl_req) begin
        ok = 1;
        break;
      end
    end
    chk("quiet_within_budget", 32'(ok), 1);
  endtask

  task automatic wait_ctrl_req(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (ctrl_req) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    bit ok;
    int k;
    reset = 1'b1;
    p1_req = 0; p1_address = '0;
    p2_req = 0; p2_wren = 0; p2_address = '0;
    p3_req = 0; p3_wren = 0; p3_address = '0;
    ctrl_ready = 0; ctrl_offset = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // p1 alone: aligned address, read, offsets 0..3.
    phase = 1; en = 3'b001; rate = 100;
    wait_ctrl_req(50, ok);
    chk("p1_burst_started", 32'(ok), 1);
    chk("p1_ctrl_address", 32'(ctrl_address), 32'h001234);
    chk("p1_ctrl_wren", 32'(ctrl_wren), 0);
    chk("p1_grant", 32'(grant), 1);
    k = 0;
    for (int i = 0; i < 50 && k < 4; i++) begin
      if (p1_ready) begin
        chk("p1_offset_seq", 32'(p1_offset), 32'(k));
        k++;
      end
      if (k < 4) begin
        @(negedge clk);
        #1;
      end
    end
    chk("p1_ready_pulses", 32'(k), 4);
    en = 3'b000;
    wait_quiet(100);

    // p3 write into its window with A000+offset data.
    en = 3'b100;
    wait_ctrl_req(50, ok);
    chk("p3_burst_started", 32'(ok), 1);
    chk("p3_ctrl_address", 32'(ctrl_address), 32'hFE0010);
    chk("p3_ctrl_wren", 32'(ctrl_wren), 1);
    chk("p3_grant", 32'(grant), 3);
    k = 0;
    for (int i = 0; i < 50 && k < 4; i++) begin
      if (ctrl_ready && ctrl_req) begin
        chk("p3_write_data", 32'(ctrl_to_mem), 32'(16'hA000 + 16'(k)));
        k++;
      end
      if (k < 4) begin
        @(negedge clk);
        #1;
      end
    end
    chk("p3_write_beats", 32'(k), 4);
    en = 3'b000;
    wait_quiet(100);

    // All three requesting continuously: strict rotation.
    phase = 0;
    gseq.delete();
    log_seq = 1;
    en = 3'b111;
    repeat (110) @(negedge clk);
    log_seq = 0;
    chk("rr_seq_length_ok", 32'(gseq.size() >= 6), 1);
    for (int i = 0; i < 6 && i < gseq.size(); i++) chk("rr_seq", 32'(gseq[i]), 32'(i % 3 + 1));
    en = 3'b000;
    wait_quiet(100);

    // Random traffic with mid-burst p2 drops and spurious controller readies.
    drop_en = 1;
    rate = 25;
    en = 3'b111;
    repeat (1500) @(negedge clk);

    // Reset after the second beat of a burst.
    rate = 60;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (mdl_mode == 1 && mdl_beats == 2) begin
        ok = 1;
        break;
      end
    end
    chk("mid_burst_found", 32'(ok), 1);
    @(posedge clk);
    #2;
    chk("pre_reset_ctrl_req", 32'(ctrl_req), 1);
    reset = 1'b0;
    #1;
    chk("async_drop_ctrl_req", 32'(ctrl_req), 0);
    rate = 100;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_ctrl_req(50, ok);
    chk("post_reset_started", 32'(ok), 1);
    chk("post_reset_winner", 32'(grant), 1);

    en = 3'b000;
    wait_quiet(300);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
